// File: rtl/life_pkg.sv
// life_pkg: shared states and defaults for the Game of Life generation engine.
package life_pkg;
    localparam int DEF_ROWS   = 4;
    localparam int DEF_COLS   = 16;
    localparam int DEF_ADDR_W = 2;
    localparam int GEN_W      = 16;

    typedef enum logic [2:0] {
        IDLE, PRIME0, PRIME1, PRIME2, CAPTURE, WRITE, FETCH, DONE
    } state_t;
endpackage

// File: rtl/life_row_next.sv
// life_row_next: B3/S23 next state of one row from its upper, own and lower rows, wrapping columns.
module life_row_next #(
    parameter int COLS = 16
) (
    input  logic [COLS-1:0] prev,
    input  logic [COLS-1:0] cur,
    input  logic [COLS-1:0] next,
    output logic [COLS-1:0] row_o
);
    for (genvar i = 0; i < COLS; i++) begin : g_cell
        localparam int L = (i + COLS - 1) % COLS;
        localparam int R = (i + 1) % COLS;
        logic [3:0] n;
        assign n = 4'(prev[L]) + 4'(prev[i]) + 4'(prev[R])
                 + 4'(cur[L])                + 4'(cur[R])
                 + 4'(next[L]) + 4'(next[i]) + 4'(next[R]);
        assign row_o[i] = (n == 4'd3) | (cur[i] & (n == 4'd2));
    end
endmodule

// File: rtl/life_gen_engine.sv
// life_gen_engine: computes one toroidal Game of Life generation in place over the row memory per start.
module life_gen_engine import life_pkg::*; #(
    parameter int ROWS   = DEF_ROWS,
    parameter int COLS   = DEF_COLS,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [GEN_W-1:0]  gen_count,
    output logic [ADDR_W-1:0] array_selector,
    output logic              write_enb,
    output logic [COLS-1:0]   alive_in_selector,
    input  logic [COLS-1:0]   alive_out_selector
);
    localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(ROWS - 1);
    localparam logic [ADDR_W-1:0] PENULT = ADDR_W'(ROWS - 2);

    state_t state_q, state_d;
    logic [ADDR_W-1:0] r_q, r_d;
    logic [COLS-1:0] prev_q, prev_d, cur_q, cur_d, next_q, next_d, row0_q, row0_d;
    logic [GEN_W-1:0] gen_q, gen_d;
    logic [COLS-1:0] row_nxt;

    life_row_next #(.COLS(COLS)) u_row (
        .prev (prev_q),
        .cur  (cur_q),
        .next (next_q),
        .row_o(row_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            r_q     <= '0;
            prev_q  <= '0;
            cur_q   <= '0;
            next_q  <= '0;
            row0_q  <= '0;
            gen_q   <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            prev_q  <= prev_d;
            cur_q   <= cur_d;
            next_q  <= next_d;
            row0_q  <= row0_d;
            gen_q   <= gen_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        r_d            = r_q;
        prev_d         = prev_q;
        cur_d          = cur_q;
        next_d         = next_q;
        row0_d         = row0_q;
        gen_d          = gen_q;
        array_selector = '0;
        write_enb      = 1'b0;
        done           = 1'b0;
        case (state_q)
            IDLE:    state_d = start ? PRIME0 : IDLE;
            PRIME0: begin
                array_selector = LAST;
                state_d        = PRIME1;
            end
            PRIME1: begin
                prev_d  = alive_out_selector;
                state_d = PRIME2;
            end
            PRIME2: begin
                array_selector = ADDR_W'(1);
                cur_d          = alive_out_selector;
                row0_d         = alive_out_selector;
                state_d        = CAPTURE;
            end
            CAPTURE: begin
                next_d  = alive_out_selector;
                state_d = WRITE;
            end
            WRITE: begin
                write_enb      = 1'b1;
                array_selector = r_q;
                prev_d         = cur_q;
                cur_d          = next_q;
                if (r_q == LAST) begin
                    state_d = DONE;
                end else begin
                    r_d = r_q + 1'b1;
                    // row 0 already holds the new generation, so reuse the saved original
                    if (r_q == PENULT) next_d = row0_q;
                    else state_d = FETCH;
                end
            end
            FETCH: begin
                array_selector = r_q + 1'b1;
                state_d        = CAPTURE;
            end
            DONE: begin
                done    = 1'b1;
                gen_d   = gen_q + 1'b1;
                r_d     = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign busy              = (state_q != IDLE);
    assign gen_count         = gen_q;
    assign alive_in_selector = write_enb ? row_nxt : '0;
endmodule
